// File: rtl/mux4_1_case_pkg.sv
// mux4_1_case_pkg: select encoding and select type shared by the mux4_1_case files
package mux4_1_case_pkg;
   typedef logic [1:0] sel_t;
   localparam sel_t SEL_P0 = 2'd0;
   localparam sel_t SEL_P1 = 2'd1;
   localparam sel_t SEL_P2 = 2'd2;
   localparam sel_t SEL_P3 = 2'd3;
endpackage

// File: rtl/mux4_1_case_if.sv
// mux4_1_case_if: select/data bus of the registered 4:1 mux
//   sel, p0..p3 : driven by master, sampled by slave
//   sout        : registered selected data, driven by slave
//   sout_par    : parity of sout, present only with MUX4_1_CASE_PARITY_EN
interface mux4_1_case_if
   import mux4_1_case_pkg::*;
#(parameter int WIDTH = 2);
   sel_t             sel;
   logic [WIDTH-1:0] p0, p1, p2, p3;
   logic [WIDTH-1:0] sout;
`ifdef MUX4_1_CASE_PARITY_EN
   logic             sout_par;
   modport master (output sel, p0, p1, p2, p3, input sout, sout_par);
   modport slave (input sel, p0, p1, p2, p3, output sout, sout_par);
`else
   modport master (output sel, p0, p1, p2, p3, input sout);
   modport slave (input sel, p0, p1, p2, p3, output sout);
`endif
endinterface

// File: rtl/mux4_1_case_comb.sv
// mux4_1_case_comb: combinational 4:1 case decode
//   sel_i          : source select
//   p0_i..p3_i     : data inputs
//   y_o            : selected data, zero for an unknown select
module mux4_1_case_comb
   import mux4_1_case_pkg::*;
#(parameter int WIDTH = 2) (
   input  sel_t             sel_i,
   input  logic [WIDTH-1:0] p0_i,
   input  logic [WIDTH-1:0] p1_i,
   input  logic [WIDTH-1:0] p2_i,
   input  logic [WIDTH-1:0] p3_i,
   output logic [WIDTH-1:0] y_o
);
   always_comb begin
      y_o = '0;
      case (sel_i)
         SEL_P0:  y_o = p0_i;
         SEL_P1:  y_o = p1_i;
         SEL_P2:  y_o = p2_i;
         SEL_P3:  y_o = p3_i;
         // X/Z selects land here so no X reaches the register
         default: y_o = '0;
      endcase
   end
endmodule

// File: rtl/mux4_1_case.sv
// mux4_1_case: registered 4:1 multiplexer, output valid one clock after select
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears sout (and sout_par)
//   bus   : slave side of mux4_1_case_if (sel, p0..p3 in; sout out)
//   Optional macro MUX4_1_CASE_PARITY_EN adds registered sout_par = ^sout.
module mux4_1_case
   import mux4_1_case_pkg::*;
#(parameter int WIDTH = 2) (
   input  logic          clk,
   input  logic          rst_n,
   mux4_1_case_if.slave  bus
);
   logic [WIDTH-1:0] sout_d, sout_q;
   mux4_1_case_comb #(.WIDTH(WIDTH)) u_comb (
      .sel_i (bus.sel),
      .p0_i  (bus.p0),
      .p1_i  (bus.p1),
      .p2_i  (bus.p2),
      .p3_i  (bus.p3),
      .y_o   (sout_d)
   );
`ifdef MUX4_1_CASE_PARITY_EN
   logic par_d, par_q;
   // parity of the decoded value, so an unknown select yields 0
   assign par_d = ^sout_d;
   assign bus.sout_par = par_q;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sout_q <= '0;
`ifdef MUX4_1_CASE_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         sout_q <= sout_d;
`ifdef MUX4_1_CASE_PARITY_EN
         par_q <= par_d;
`endif
      end
   end
   assign bus.sout = sout_q;
endmodule

// File: tb/tb_mux4_1_case.sv
// tb_mux4_1_case: directed self-checking bench for mux4_1_case (WIDTH=2)
module tb_mux4_1_case;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   mux4_1_case_if #(.WIDTH(2)) bus ();
   mux4_1_case #(.WIDTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic set_const_inputs();
      bus.p0 = 2'b00;
      bus.p1 = 2'b01;
      bus.p2 = 2'b10;
      bus.p3 = 2'b11;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      bus.sel = 2'd3;
      set_const_inputs();
      #1;
      n_chk++;
      if (bus.sout !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_no_edge: sout=%b expected=00", bus.sout);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (bus.sout !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: sout=%b expected=00", i, bus.sout);
         end
      end
   endtask
   task automatic test_sequence();
      logic [1:0] sels [5] = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd2};
      logic [1:0] exps [5] = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b10};
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         bus.sel = sels[i];
         @(posedge clk);
         #1;
         n_chk++;
         if (bus.sout !== exps[i]) begin
            n_fail++;
            $display("FAIL seq[%0d] sel=%0d: sout=%b expected=%b", i, sels[i], bus.sout, exps[i]);
         end
      end
   endtask
   task automatic test_midcycle();
      @(negedge clk);
      bus.sel = 2'd3;
      #2;
      n_chk++;
      if (bus.sout !== 2'b10) begin
         n_fail++;
         $display("FAIL midcycle_hold: sout=%b expected=10", bus.sout);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.sout !== 2'b11) begin
         n_fail++;
         $display("FAIL midcycle_update: sout=%b expected=11", bus.sout);
      end
   endtask
   task automatic test_async_reset();
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.sout !== 2'b00) begin
         n_fail++;
         $display("FAIL async_reset: sout=%b expected=00", bus.sout);
      end
      #1;
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (bus.sout !== 2'b00) begin
         n_fail++;
         $display("FAIL async_release_hold: sout=%b expected=00", bus.sout);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.sout !== 2'b11) begin
         n_fail++;
         $display("FAIL async_release_edge: sout=%b expected=11", bus.sout);
      end
   endtask
   task automatic test_x_sel();
      @(negedge clk);
      bus.sel = 2'bxx;
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.sout !== 2'b00) begin
         n_fail++;
         $display("FAIL x_sel: sout=%b expected=00", bus.sout);
      end
   endtask
   task automatic test_back_to_back();
      logic [1:0] exps [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
      @(negedge clk);
      bus.p0 = 2'b11;
      bus.p1 = 2'b10;
      bus.p2 = 2'b01;
      bus.p3 = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         bus.sel = 2'(i);
         @(posedge clk);
         #1;
         n_chk++;
         if (bus.sout !== exps[i]) begin
            n_fail++;
            $display("FAIL b2b[%0d]: sout=%b expected=%b", i, bus.sout, exps[i]);
         end
      end
      @(negedge clk);
      set_const_inputs();
   endtask
`ifdef MUX4_1_CASE_PARITY_EN
   task automatic test_parity();
      logic [1:0] sels [3] = '{2'd1, 2'd3, 2'd0};
      logic [1:0] exps [3] = '{2'b01, 2'b11, 2'b00};
      logic       pars [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.sel = sels[i];
         @(posedge clk);
         #1;
         n_chk++;
         if (bus.sout !== exps[i] || bus.sout_par !== pars[i]) begin
            n_fail++;
            $display("FAIL parity[%0d]: sout=%b par=%b expected sout=%b par=%b", i, bus.sout, bus.sout_par, exps[i], pars[i]);
         end
      end
   endtask
`endif
   initial begin
      test_reset();
      test_sequence();
      test_midcycle();
      test_async_reset();
      test_x_sel();
      test_back_to_back();
`ifdef MUX4_1_CASE_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
